mult_4bit_seq: RTL

Sequential 4x4 unsigned shift-add multiplier that time-shares one fulladder_4bit instance over four iterations.
It is the first multi-cycle controller in the Adder Subtractor project: an FSM plus registers wrapped around the existing 4-bit adder datapath.
It accepts a Start pulse, iterates one partial product per clock and presents an 8-bit Product with a one-cycle Done strobe.

---
 rtl/mult_4bit_seq_pkg.sv | 17 +
 rtl/mult_4bit_seq_if.sv | 25 ++
 rtl/mult_4bit_seq_fulladder.sv | 21 ++
 rtl/mult_4bit_seq.sv | 97 +++++++++
 4 files changed

// File: rtl/mult_4bit_seq_pkg.sv
// Shared constants for the sequential 4x4 shift-add multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_pkg;

    // Two-bit controller encoding; 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One partial product per multiplier bit.
    localparam int ITER_CNT = 4;
    localparam int CNT_W    = 2;

endpackage : mult_pkg

// File: rtl/mult_4bit_seq_if.sv
// Request/result bundle between a multiplier client and mult_4bit_seq.
// Latency: n/a (wiring only).
// Backpressure: none; Start is ignored while Busy is high, with no queueing.
interface mult_4bit_seq_if;

    logic       Start;
    logic [3:0] A;
    logic [3:0] B;
    logic [7:0] Product;
    logic       Done;
    logic       Busy;

    // Client side: issues operands, observes the result.
    modport master (
        output Start, A, B,
        input  Product, Done, Busy
    );

    // Multiplier side.
    modport slave (
        input  Start, A, B,
        output Product, Done, Busy
    );

endinterface : mult_4bit_seq_if

// File: rtl/mult_4bit_seq_fulladder.sv
// 4-bit adder/subtractor datapath: Sum = A + B (Sub=0) or A - B (Sub=1).
// Latency: purely combinational.
// Backpressure: none.
module fulladder_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Sub,
    output logic [3:0] Sum,
    output logic       Cout
);

    logic [3:0] w_b_eff;
    logic [4:0] w_sum5;

    // Subtraction is two's complement: invert B and inject Sub as carry-in.
    assign w_b_eff = B ^ {4{Sub}};
    assign w_sum5  = {1'b0, A} + {1'b0, w_b_eff} + {4'b0000, Sub};
    assign Sum     = w_sum5[3:0];
    assign Cout    = w_sum5[4];

endmodule : fulladder_4bit

// File: rtl/mult_4bit_seq.sv
// Sequential 4x4 unsigned shift-add multiplier sharing one fulladder_4bit.
// Latency: Start edge is cycle 0, Done strobes in cycle 5; Start-to-Start 6 cycles.
// Backpressure: Start is only sampled in IDLE; requests while Busy are dropped.
module mult_4bit_seq
    import mult_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    mult_4bit_seq_if.slave   bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER_CNT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_areg;
    logic [3:0]       w_areg_nxt;
    logic [8:0]       r_acc;        // {carry, hi[3:0], lo[3:0]}
    logic [8:0]       w_acc_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [7:0]       r_product;
    logic [7:0]       w_product_nxt;
    logic [3:0]       w_sum;
    logic             w_cout;

    // Single shared adder: accumulator high nibble plus captured multiplicand.
    fulladder_4bit u_add (
        .A    (r_acc[7:4]),
        .B    (r_areg),
        .Sub  (1'b0),
        .Sum  (w_sum),
        .Cout (w_cout)
    );

    // Next-state and datapath update; everything holds unless a state acts on it.
    always_comb begin
        w_state_nxt   = r_state;
        w_areg_nxt    = r_areg;
        w_acc_nxt     = r_acc;
        w_cnt_nxt     = r_cnt;
        w_product_nxt = r_product;
        case (r_state)
            ST_IDLE: begin
                if (bus.Start) begin
                    w_areg_nxt  = bus.A;
                    w_acc_nxt   = {5'b00000, bus.B};
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                // The multiplier bit under test sits in lo[0]; the adder
                // carry lands in bit 7 as the whole accumulator shifts right.
                if (r_acc[0]) begin
                    w_acc_nxt = {1'b0, w_cout, w_sum, r_acc[3:1]};
                end else begin
                    w_acc_nxt = {1'b0, r_acc[7:4], r_acc[3:1]};
                end
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == LAST_CNT) begin
                    // Load the result now so it is visible during the DONE cycle.
                    w_product_nxt = w_acc_nxt[7:0];
                    w_state_nxt   = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; synchronous reset aborts any operation.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_areg    <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_areg    <= w_areg_nxt;
            r_acc     <= w_acc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_product <= w_product_nxt;
        end
    end

    assign bus.Product = r_product;
    assign bus.Done    = (r_state == ST_DONE);
    assign bus.Busy    = (r_state != ST_IDLE);

endmodule : mult_4bit_seq
